transmit_fifo: RTL
==================

# transmit_fifo

Transmit-side buffer of the APB UART, sitting between the APB register interface (producer) and the TX frame FSM (consumer). Buffers up to 32 pre-formatted 12-bit frames in FIFO mode, or holds a single frame in bypass mode. Presents the head entry to the TX FSM on a valid/request handshake and reports fill status, pointers and a sticky overflow flag back to the APB side.

## Interface
- DATA_W, 12, frame width (data + parity + stop bits, as formatted by the APB side)
- DEPTH, 32, FIFO entries; must be a power of two
- AW, 5, address width, log2(DEPTH)
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- wr_en_i  in  1  APB write strobe; one push per cycle high
- wr_data_i  in  DATA_W  frame to push
- fifo_en_i  in  1  1 = FIFO mode (DEPTH entries), 0 = bypass mode (1 entry)
- tx_en_i  in  1  transmitter enable; 0 blocks pops only
- tx_req_i  in  1  TX FSM pops the head entry (loads its shift register)
- clr_i  in  1  synchronous flush
- tx_data_o  out  DATA_W  head entry; 0 when tx_valid_o = 0
- tx_valid_o  out  1  head entry valid (not empty)
- full_o  out  1  no free entry
- empty_o  out  1  no entry stored
- count_o  out  AW+1  entries stored, 0..DEPTH
- ovf_o  out  1  sticky: a push was dropped
- tx_ptr_addr_wr_o  out  AW  write pointer
- tx_ptr_addr_rd_o  out  AW  read pointer

## Operation
- Storage: DEPTH x DATA_W register array, not reset. Pointers wrap modulo DEPTH (31 -> 0). count_o is the authoritative fill level; full_o = (count_o == capacity), empty_o = (count_o == 0), tx_valid_o = ~empty_o.
- Capacity: DEPTH in FIFO mode, 1 in bypass mode.
- Push: accepted iff wr_en_i and ~full_o (full_o as at the start of the cycle). Writes mem[wr_ptr] (FIFO) or the holding register (bypass); wr_ptr increments in FIFO mode only. Pushes are accepted regardless of tx_en_i.
- Drop: wr_en_i while full_o sets ovf_o; data discarded, pointers/count unchanged. This holds even if a pop happens in the same cycle.
- Pop: occurs iff tx_req_i, tx_en_i and tx_valid_o. In FIFO mode rd_ptr increments; tx_req_i while empty or tx_en_i = 0 is ignored.
- Simultaneous accepted push and pop: count unchanged, both pointers advance. In bypass mode the holding register stays valid with the new data.
- tx_data_o = mem[rd_ptr] (FIFO) or the holding register (bypass), combinationally from registered state, forced to 0 when empty.
- Flush: clears wr_ptr, rd_ptr, count and the bypass valid; array contents untouched. Any push or pop in that cycle is discarded. A flush is triggered by:
  - clr_i; this also clears ovf_o.
  - fifo_en_i differing from its registered copy fifo_en_q; this does not clear ovf_o. The flush takes effect on the edge where the change is first sampled, and fifo_en_q updates on the same edge.
- Priority: rst_i > clr_i > mode-change flush > push/pop.
- Pointers are held at 0 in bypass mode.

## Timing
- Reset (rst_i high at an edge):
  - Outputs: tx_data_o = 0, tx_valid_o = 0, full_o = 0, empty_o = 1, count_o = 0, ovf_o = 0, both pointers 0.
  - Internal: fifo_en_q loads fifo_en_i, so there is no spurious flush after reset.
- Push latency: a push accepted at edge N is visible after edge N: tx_valid_o = 1, tx_data_o = pushed data if previously empty, count_o + 1.
- Pop latency: a pop at edge N presents the next entry (or tx_valid_o = 0) after edge N.
- Full path: the 32nd push at edge N asserts full_o after N. A push at N+1 is dropped and ovf_o asserts after N+1.
- All status outputs are registered or derived from registered state only; no combinational path from any input to any output.
- Reset or clr_i mid-burst: takes effect at that edge; the in-flight push or pop is lost.

## Test plan
- Fill and overflow: 32 pushes 0x001..0x020, then a 33rd push of 0xFFF -> full_o = 1 and count_o = 32 after the 32nd; ovf_o = 1 after the 33rd; 32 pops return 0x001..0x020 in order; empty_o = 1.
- Wrap-around: push 20, pop 20, push 20 (0x100..0x113), pop 20 -> data in order; wr_ptr passes 31 -> 0 and ends at 8; count_o returns to 0.
- Simultaneous push and pop: with count_o = 5, push 0x0AA and pop in the same cycle -> count_o stays 5; head advances; 0x0AA is popped 5th.
- tx_en_i gating: with 3 entries stored, tx_en_i = 0 and tx_req_i = 1 for 4 cycles -> count_o stays 3; with tx_en_i = 1, pops proceed.
- Bypass mode: fifo_en_i = 0, push 0x155 -> full_o = 1, tx_data_o = 0x155; a second push 0x0F0 -> dropped, ovf_o = 1; pop -> empty_o = 1.
- Flush and mode change: with 10 entries, clr_i -> count_o = 0, ovf_o = 0, pointers 0. Refill 4 entries, toggle fifo_en_i -> flushed on the next edge, ovf_o unchanged. Assert rst_i during a push -> reset values, push lost.

Source files
------------

// File: rtl/transmit_fifo.sv
// Transmit-side frame buffer for the APB UART: 32-entry FIFO or single-entry
// bypass holding register, presenting the head frame to the TX FSM.
module transmit_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              fifo_en_i,
  input  logic              tx_en_i,
  input  logic              tx_req_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              ovf_o,
  output logic [AW-1:0]     tx_ptr_addr_wr_o,
  output logic [AW-1:0]     tx_ptr_addr_rd_o
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_hold;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              r_ovf;
  logic              r_fifo_en_q;

  logic [AW:0]       w_cap;
  logic              w_full;
  logic              w_empty;
  logic              w_mode_chg;
  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic [DATA_W-1:0] w_head;

  // Mode follows the registered copy, so status never depends on live inputs.
  always_comb begin
    w_cap      = r_fifo_en_q ? DEPTH_C : ONE_C;
    w_full     = (r_count == w_cap);
    w_empty    = (r_count == '0);
    w_mode_chg = (fifo_en_i != r_fifo_en_q);
    w_flush    = clr_i | w_mode_chg;
    w_push     = wr_en_i & ~w_full & ~w_flush & ~rst_i;
    w_pop      = tx_req_i & tx_en_i & ~w_empty & ~w_flush & ~rst_i;
    w_drop     = wr_en_i & w_full & ~w_flush;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_fifo_en_q <= fifo_en_i;
    end else begin
      r_fifo_en_q <= fifo_en_i;
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        if (clr_i) r_ovf <= 1'b0;
      end else begin
        if (w_drop) r_ovf <= 1'b1;
        if (w_push && r_fifo_en_q) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop && r_fifo_en_q)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push && !w_pop)      r_count  <= r_count + ONE_C;
        else if (!w_push && w_pop) r_count  <= r_count - ONE_C;
      end
    end
  end

  // Storage is never reset; validity is tracked solely by r_count.
  always_ff @(posedge clk_i) begin
    if (w_push && r_fifo_en_q)  r_mem[r_wr_ptr] <= wr_data_i;
    if (w_push && !r_fifo_en_q) r_hold          <= wr_data_i;
  end

  always_comb begin
    w_head           = r_fifo_en_q ? r_mem[r_rd_ptr] : r_hold;
    tx_data_o        = w_empty ? '0 : w_head;
    tx_valid_o       = ~w_empty;
    full_o           = w_full;
    empty_o          = w_empty;
    count_o          = r_count;
    ovf_o            = r_ovf;
    tx_ptr_addr_wr_o = r_wr_ptr;
    tx_ptr_addr_rd_o = r_rd_ptr;
  end

endmodule
